ps2_key_decoder: RTL and testbench



---
 rtl/ps2_key_decoder_pkg.sv | 20 ++
 rtl/ps2_key_decoder_if.sv | 22 ++
 rtl/ps2_key_decoder_frame_rx.sv | 116 +++++++++++
 rtl/ps2_key_decoder.sv | 92 +++++++++
 tb/tb_ps2_key_decoder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 keyboard decoder: scan-code prefixes,
// decoder states and the frame parity helper.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_e;

  // Odd parity holds when data plus parity bit has an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Keyboard-side pins and decoded key outputs of the PS/2 decoder.
interface ps2_key_decoder_if;

  logic       ps2_clk;
  logic       ps2_data;
  logic       pressed;
  logic [7:0] scancode;
  logic       ext;
  logic       key_event;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  pressed, scancode, ext, key_event, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output pressed, scancode, ext, key_event, frame_err
  );

endinterface

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: synchronizes the pads, shifts in 11-bit frames,
// checks start/parity/stop and discards stalled partial frames.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          start_bad_q, start_bad_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          frame_err_q, frame_err_d;
  logic          fall_s;
  logic          bit_in_s;

  assign fall_s   = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in_s = data_sync_q[1];

  always_comb begin
    clk_sync_d   = {clk_sync_q[1:0], ps2_clk};
    data_sync_d  = {data_sync_q[0], ps2_data};
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    start_bad_d  = start_bad_q;
    parity_d     = parity_q;
    to_cnt_d     = to_cnt_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_err_d  = 1'b0;
    if (fall_s) begin
      to_cnt_d = '0;
      case (bit_cnt_q)
        4'd0: begin
          start_bad_d = bit_in_s;
          bit_cnt_d   = 4'd1;
        end
        4'd9: begin
          parity_d  = bit_in_s;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          if (!start_bad_q && odd_parity_ok(shift_q, parity_q) && bit_in_s) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: begin
          // Data bits arrive LSB first, so shift in from the top.
          shift_d   = {bit_in_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      endcase
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d   = 4'd0;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Synchronizers idle high so release from reset never fakes a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q   <= 3'b111;
      data_sync_q  <= 2'b11;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      start_bad_q  <= 1'b0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'h00;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      start_bad_q  <= start_bad_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign rx_byte    = byte_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder top: turns make/break/extended scan-code sequences into
// a held-key level, the current scan code and a key-press pulse.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic               clk,
  input logic               rst,
  ps2_key_decoder_if.slave  bus
);

  logic       rx_valid_s;
  logic [7:0] rx_byte_s;
  logic       rx_err_s;

  dec_state_e state_q;
  logic       pressed_q;
  logic [7:0] scancode_q;
  logic       ext_q;
  logic       key_event_q;

  logic       make_ext_s;
  logic       make_new_s;
  logic       brk_hit_s;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .byte_valid (rx_valid_s),
    .rx_byte    (rx_byte_s),
    .frame_err  (rx_err_s)
  );

  // A repeat of the held key is not a new press.
  assign make_ext_s = (state_q == EXT);
  assign make_new_s = ~pressed_q | ({make_ext_s, rx_byte_s} != {ext_q, scancode_q});
  assign brk_hit_s  = pressed_q & (rx_byte_s == scancode_q) & (ext_q == (state_q == EXT_BRK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pressed_q   <= 1'b0;
      scancode_q  <= 8'h00;
      ext_q       <= 1'b0;
      key_event_q <= 1'b0;
    end else begin
      key_event_q <= 1'b0;
      if (rx_err_s) begin
        state_q <= IDLE;
      end else if (rx_valid_s) begin
        case (state_q)
          IDLE, EXT: begin
            if (state_q == IDLE && rx_byte_s == PS2_PREFIX_EXT) begin
              state_q <= EXT;
            end else if (rx_byte_s == PS2_PREFIX_BRK) begin
              state_q <= (state_q == EXT) ? EXT_BRK : BRK;
            end else begin
              pressed_q   <= 1'b1;
              scancode_q  <= rx_byte_s;
              ext_q       <= make_ext_s;
              key_event_q <= make_new_s;
              state_q     <= IDLE;
            end
          end
          BRK, EXT_BRK: begin
            if (brk_hit_s) begin
              pressed_q <= 1'b0;
            end else begin
              pressed_q <= pressed_q;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign bus.pressed   = pressed_q;
  assign bus.scancode  = scancode_q;
  assign bus.ext       = ext_q;
  assign bus.key_event = key_event_q;
  assign bus.frame_err = rx_err_s;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by
// random scan-code traffic, compared against a key-state reference model.
module tb_ps2_key_decoder;

  localparam int TO = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed pulse counts and pulse-width violations.
  int   ev_cnt   = 0;
  int   err_cnt  = 0;
  int   wide_cnt = 0;
  logic prev_ke  = 1'b0;
  logic prev_fe  = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.key_event) ev_cnt++;
      if (bus.frame_err) err_cnt++;
      if ((bus.key_event && prev_ke) || (bus.frame_err && prev_fe)) wide_cnt++;
    end
    prev_ke = bus.key_event;
    prev_fe = bus.frame_err;
  end

  // Reference model: what key is held and which prefixes are pending.
  bit       m_pressed = 1'b0;
  bit       m_ext     = 1'b0;
  bit [7:0] m_code    = 8'h00;
  bit       m_pe      = 1'b0;
  bit       m_pb      = 1'b0;
  int       m_events  = 0;
  int       m_errs    = 0;

  task automatic model_byte(input bit [7:0] b);
    if (b == 8'hE0 && !m_pe && !m_pb) begin
      m_pe = 1'b1;
    end else if (b == 8'hF0 && !m_pb) begin
      m_pb = 1'b1;
    end else if (m_pb) begin
      if (m_pressed && b == m_code && m_ext == m_pe) m_pressed = 1'b0;
      m_pe = 1'b0;
      m_pb = 1'b0;
    end else begin
      if (!m_pressed || b != m_code || m_ext != m_pe) m_events++;
      m_pressed = 1'b1;
      m_code    = b;
      m_ext     = m_pe;
      m_pe      = 1'b0;
    end
  endtask

  task automatic model_err();
    m_errs++;
    m_pe = 1'b0;
    m_pb = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pressed"},  {31'd0, bus.pressed}, {31'd0, m_pressed});
    chk({tag, "_scancode"}, {24'd0, bus.scancode}, {24'd0, m_code});
    chk({tag, "_ext"},      {31'd0, bus.ext},      {31'd0, m_ext});
    chk({tag, "_events"},   ev_cnt,  m_events);
    chk({tag, "_errs"},     err_cnt, m_errs);
    chk({tag, "_width"},    wide_cnt, 32'd0);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bp, input bit bs);
    logic par;
    par = (~^b) ^ bp;
    return {~bs, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = f[i];
      wait_clk(5);
      bus.ps2_clk = 1'b0;
      wait_clk(10);
      bus.ps2_clk = 1'b1;
      wait_clk(5);
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0, 1'b0), 11);
    wait_clk(5);
    model_byte(b);
  endtask

  task automatic send_bad(input logic [7:0] b, input bit bp, input bit bs);
    send_bits(mk_frame(b, bp, bs), 11);
    wait_clk(5);
    model_err();
  endtask

  logic [7:0] keys [5] = '{8'h1C, 8'h23, 8'h75, 8'h6B, 8'h5A};

  initial begin
    logic [7:0] k;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    check_all("reset");
    chk("reset_key_event", {31'd0, bus.key_event}, 32'd0);

    // Reset in the middle of a frame.
    send_byte(8'h1C);
    check_all("pre_reset_make");
    send_bits(mk_frame(8'h23, 1'b0, 1'b0), 4);
    rst = 1'b1;
    wait_clk(3);
    chk("midrst_pressed",   {31'd0, bus.pressed},   32'd0);
    chk("midrst_scancode",  {24'd0, bus.scancode},  32'd0);
    chk("midrst_ext",       {31'd0, bus.ext},       32'd0);
    chk("midrst_key_event", {31'd0, bus.key_event}, 32'd0);
    chk("midrst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    m_pressed = 1'b0; m_code = 8'h00; m_ext = 1'b0; m_pe = 1'b0; m_pb = 1'b0;
    rst = 1'b0;
    wait_clk(5);
    send_byte(8'h1C);
    check_all("post_reset_make");

    // Make then break.
    send_byte(8'hF0); send_byte(8'h1C);
    check_all("break_1c");
    send_byte(8'h1C);
    check_all("make_1c");
    send_byte(8'hF0); send_byte(8'h1C);
    check_all("break_1c_again");

    // Extended key; a plain break must not release it.
    send_byte(8'hE0); send_byte(8'h75);
    check_all("ext_make_75");
    send_byte(8'hF0); send_byte(8'h75);
    check_all("plain_break_75");
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check_all("ext_break_75");

    // Typematic repeats.
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h1C);
      check_all("typematic_1c");
    end
    send_byte(8'h23);
    check_all("new_key_23");

    // Frame errors.
    send_byte(8'hF0); send_byte(8'h23);
    send_bad(8'h1C, 1'b1, 1'b0);
    check_all("parity_err");
    send_byte(8'hE0);
    send_bad(8'h75, 1'b0, 1'b1);
    send_byte(8'h75);
    check_all("stop_err_drops_e0");

    // Timeout after 5 bits.
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 5);
    wait_clk(TO + 20);
    model_err();
    check_all("timeout");
    send_byte(8'h1C);
    check_all("after_timeout");

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      k = keys[$urandom_range(0, 4)];
      case ($urandom_range(0, 5))
        0: send_byte(k);
        1: begin send_byte(8'hE0); send_byte(k); end
        2: begin send_byte(8'hF0); send_byte(k); end
        3: begin send_byte(8'hE0); send_byte(8'hF0); send_byte(k); end
        4: send_byte(8'($urandom_range(0, 255)));
        default: send_bad(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      endcase
      check_all("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired before test completion");
    $fatal(1, "watchdog");
  end

endmodule
